// File: rtl/mux_z_deserializer.sv
// mux_z_deserializer: packs qualified Z bits from the late-select mux LSB-first into WIDTH-bit
// words on a valid/ready output. Optional parity generation/check under MUX_Z_DESER_PARITY_EN.
module mux_z_deserializer #(
  parameter int WIDTH  = 8,
  parameter int DROP_W = 4,
  localparam int LW    = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              z_in,
  input  logic              z_valid,
  input  logic              z_late,
  input  logic              flush,
  output logic [WIDTH-1:0]  word_out,
  output logic [LW-1:0]     word_len,
  output logic [LW-1:0]     late_cnt,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              drop_sticky
`ifdef MUX_Z_DESER_PARITY_EN
  ,
  input  logic              par_in,
  output logic              word_par,
  output logic              par_err
`endif
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [LW-1:0]    cnt;
  logic [LW-1:0]    late_acc;

  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] sreg_nxt;
  logic [LW-1:0]    cnt_nxt;
  logic [LW-1:0]    late_nxt;
  logic             handshake;
  logic             take_bit;
  logic             emit;
  logic             drop;

  // Accumulators are zero at every word boundary, so the handshake-cycle bit can reuse the
  // ordinary insert path and lands at position 0 without a bubble.
  always_comb begin
    bit_mask  = {{(WIDTH-1){1'b0}}, 1'b1} << cnt;
    handshake = (state == HOLD) && word_ready;
    take_bit  = z_valid && ((state == COLLECT) || handshake);
    sreg_nxt  = (take_bit && z_in) ? (sreg | bit_mask) : sreg;
    cnt_nxt   = cnt + {{(LW-1){1'b0}}, take_bit};
    late_nxt  = late_acc + {{(LW-1){1'b0}}, (take_bit && z_late)};
    emit      = (state == COLLECT) &&
                ((cnt_nxt == LW'(WIDTH)) || (flush && (cnt_nxt != '0)));
    drop      = (state == HOLD) && !word_ready && z_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      sreg       <= '0;
      cnt        <= '0;
      late_acc   <= '0;
      word_out   <= '0;
      word_len   <= '0;
      late_cnt   <= '0;
      word_valid <= 1'b0;
    end else if (emit) begin
      state      <= HOLD;
      word_out   <= sreg_nxt;
      word_len   <= cnt_nxt;
      late_cnt   <= late_nxt;
      word_valid <= 1'b1;
      sreg       <= '0;
      cnt        <= '0;
      late_acc   <= '0;
    end else begin
      sreg     <= sreg_nxt;
      cnt      <= cnt_nxt;
      late_acc <= late_nxt;
      if (handshake) begin
        state      <= COLLECT;
        word_valid <= 1'b0;
      end
    end
  end

  // Drop accounting saturates rather than wrapping so a long stall never reads as a short one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt    <= '0;
      drop_sticky <= 1'b0;
    end else if (drop) begin
      drop_sticky <= 1'b1;
      if (drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

`ifdef MUX_Z_DESER_PARITY_EN
  logic par_nxt;
  assign par_nxt = ^sreg_nxt;

  // Unused upper bits are zero, so XOR over the whole word equals parity of the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_par <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      par_err <= 1'b0;
      if (emit) begin
        word_par <= par_nxt;
        par_err  <= (cnt_nxt == LW'(WIDTH)) && (par_in != par_nxt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mux_z_deserializer.sv
// Testbench for mux_z_deserializer: directed literal cases plus randomized traffic checked
// every cycle against a queue-based model. Parity checks follow MUX_Z_DESER_PARITY_EN.
module tb_mux_z_deserializer;
  localparam int WIDTH    = 8;
  localparam int DROP_W   = 4;
  localparam int LW       = $clog2(WIDTH + 1);
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              z_in = 1'b0, z_valid = 1'b0, z_late = 1'b0, flush = 1'b0;
  logic              word_ready = 1'b1;
  logic              par_in = 1'b0;
  logic [WIDTH-1:0]  word_out;
  logic [LW-1:0]     word_len, late_cnt;
  logic              word_valid;
  logic [DROP_W-1:0] drop_cnt;
  logic              drop_sticky;
`ifdef MUX_Z_DESER_PARITY_EN
  logic              word_par, par_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mux_z_deserializer #(.WIDTH(WIDTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst_n(rst_n), .z_in(z_in), .z_valid(z_valid), .z_late(z_late),
    .flush(flush), .word_out(word_out), .word_len(word_len), .late_cnt(late_cnt),
    .word_valid(word_valid), .word_ready(word_ready), .drop_cnt(drop_cnt),
    .drop_sticky(drop_sticky)
`ifdef MUX_Z_DESER_PARITY_EN
    , .par_in(par_in), .word_par(word_par), .par_err(par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of received bits, a pending-word record and a drop tally.
  bit     bq[$];
  int     m_lacc = 0;
  bit     m_valid = 0;
  int     m_word = 0, m_len = 0, m_late = 0, m_drops = 0;
  bit     m_sticky = 0, m_par = 0, m_perr = 0;

  task automatic m_push();
    bq.push_back(z_in);
    if (z_late) m_lacc++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      bq.delete();
      m_lacc = 0; m_valid = 0; m_word = 0; m_len = 0; m_late = 0;
      m_drops = 0; m_sticky = 0; m_par = 0; m_perr = 0;
    end else begin
      m_perr = 0;
      if (m_valid) begin
        if (word_ready) begin
          m_valid = 0;
          if (z_valid) m_push();
        end else if (z_valid) begin
          m_drops++;
          m_sticky = 1;
        end
      end else begin
        if (z_valid) m_push();
        if (bq.size() == WIDTH || (flush && bq.size() > 0)) begin
          int ones;
          ones = 0;
          m_word = 0;
          for (int i = 0; i < bq.size(); i++)
            if (bq[i]) begin
              m_word += (1 << i);
              ones++;
            end
          m_len   = bq.size();
          m_late  = m_lacc;
          m_valid = 1;
          m_par   = ones % 2;
          m_perr  = (m_len == WIDTH) && (par_in != m_par);
          bq.delete();
          m_lacc = 0;
        end
      end
    end
  end

  // Single compare process, sampling on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_valid", word_valid, 0);
      chk("rst_word", word_out, 0);
      chk("rst_len", word_len, 0);
      chk("rst_late", late_cnt, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_sticky", drop_sticky, 0);
    end else begin
      chk("word_valid", word_valid, m_valid);
      if (m_valid) begin
        chk("word_out", word_out, m_word);
        chk("word_len", word_len, m_len);
        chk("late_cnt", late_cnt, m_late);
`ifdef MUX_Z_DESER_PARITY_EN
        chk("word_par", word_par, m_par);
`endif
      end
      chk("drop_cnt", drop_cnt, (m_drops > DROP_MAX) ? DROP_MAX : m_drops);
      chk("drop_sticky", drop_sticky, m_sticky);
`ifdef MUX_Z_DESER_PARITY_EN
      chk("par_err", par_err, m_perr);
`endif
    end
  end

  task automatic drive(input logic v, input logic b, input logic l, input logic f,
                       input logic r);
    @(negedge clk);
    z_valid = v; z_in = b; z_late = l; flush = f; word_ready = r;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  logic [7:0] pat;
  int         ready_pct;

  initial begin
    pat = 8'h4D;
    #1 rst_n = 1'b0;
    #12 rst_n = 1'b1;

    // Full word, ready high.
    for (int i = 0; i < 8; i++) drive(1, pat[i], 0, 0, 1);
    after_edge();
    chk("full_valid", word_valid, 1);
    chk("full_word", word_out, 8'h4D);
    chk("full_len", word_len, 8);
    chk("full_late", late_cnt, 0);
    drive(0, 0, 0, 0, 1);
    after_edge();
    chk("full_one_cycle", word_valid, 0);

    // Late tagging on bits 2 and 5.
    for (int i = 0; i < 8; i++) drive(1, pat[i], (i == 2 || i == 5), 0, 1);
    after_edge();
    chk("late_word", word_out, 8'h4D);
    chk("late_cnt2", late_cnt, 2);
    drive(0, 0, 0, 0, 1);

    // Back-pressure: three drops, word held, then handshake with a new bit 0.
    pulse_reset();
    for (int i = 0; i < 8; i++) drive(1, pat[i], 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0);
    after_edge();
    chk("bp_drop", drop_cnt, 3);
    chk("bp_sticky", drop_sticky, 1);
    chk("bp_word", word_out, 8'h4D);
    chk("bp_valid", word_valid, 1);
    drive(1, 1, 0, 0, 1);
    for (int i = 0; i < 7; i++) drive(1, 0, 0, 0, 1);
    after_edge();
    chk("bp_next_valid", word_valid, 1);
    chk("bp_next_word", word_out, 8'h01);
    chk("bp_drop_kept", drop_cnt, 3);
    drive(0, 0, 0, 0, 1);

    // Flush of a partial word, then flush with nothing collected.
    drive(1, 1, 0, 0, 1); drive(1, 1, 0, 0, 1); drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    after_edge();
    chk("flush_valid", word_valid, 1);
    chk("flush_word", word_out, 8'h03);
    chk("flush_len", word_len, 3);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    after_edge();
    chk("flush_empty", word_valid, 0);
    drive(0, 0, 0, 0, 1);

    // Reset mid-word discards residue.
    for (int i = 0; i < 5; i++) drive(1, 1, 1, 0, 1);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk("mid_rst_valid", word_valid, 0);
    chk("mid_rst_word", word_out, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) drive(1, (i == 7), 0, 0, 1);
    after_edge();
    chk("clean_word", word_out, 8'h80);
    chk("clean_late", late_cnt, 0);
    drive(0, 0, 0, 0, 1);

    // Saturation after 20 drops.
    pulse_reset();
    for (int i = 0; i < 8; i++) drive(1, pat[i], 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0);
    after_edge();
    chk("sat_drop", drop_cnt, 15);
    chk("sat_word", word_out, 8'h4D);
    drive(0, 0, 0, 0, 1);

`ifdef MUX_Z_DESER_PARITY_EN
    // Wrong par_in on 8'h4D (even parity 0): one-cycle par_err.
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, pat[i], 0, 0, 0);
      par_in = (i == 7);
    end
    after_edge();
    chk("par_err_set", par_err, 1);
    chk("par_word_par", word_par, 0);
    drive(0, 0, 0, 0, 0);
    par_in = 1'b0;
    after_edge();
    chk("par_err_pulse", par_err, 0);
    chk("par_hold_valid", word_valid, 1);
    drive(0, 0, 0, 0, 1);
`endif

    // Randomized traffic.
    ready_pct = 90;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: ready_pct = 15;
          1: ready_pct = 60;
          default: ready_pct = 95;
        endcase
      end
      if ($urandom_range(0, 499) == 0) pulse_reset();
      drive(($urandom_range(0, 99) < 70), 1'($urandom), ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < ready_pct));
      par_in = 1'($urandom);
    end
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
